// File: rtl/cmdq_pkg.sv
// Shared types and constants for the DDR5 collapsing command queue.
// The read-prioritisation option is selected with the CMDQ_READ_PRIO_EN macro.
package cmdq_pkg;

   // Default address width for the packed entry type below.
   localparam int CMDQ_ADDR_W = 32;

   // Command type encoding carried in each entry.
   localparam logic CMD_RD = 1'b0;
   localparam logic CMD_WR = 1'b1;

   // Per-slot update select driven by the queue control logic.
   localparam logic [1:0] SLOT_HOLD  = 2'd0;
   localparam logic [1:0] SLOT_SHIFT = 2'd1;
   localparam logic [1:0] SLOT_LOAD  = 2'd2;

   // One queue entry: valid flag, read/write flag and address payload.
   typedef struct packed {
      logic                   valid;
      logic                   rw;
      logic [CMDQ_ADDR_W-1:0] addr;
   } cmdq_entry_t;

endpackage

// File: rtl/cmdq_slot.sv
// Single command-queue entry register.
// It can hold, take the entry from the slot above (collapse), or load the input command.
module cmdq_slot
   import cmdq_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        mode,
   input  logic              load_rw,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic              shift_valid,
   input  logic              shift_rw,
   input  logic [ADDR_W-1:0] shift_addr,
   output logic              valid,
   output logic              rw,
   output logic [ADDR_W-1:0] addr
);

   // Entry register: clear on reset, otherwise follow the select from the queue control.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= 1'b0;
         rw    <= 1'b0;
         addr  <= '0;
      end else begin
         case (mode)
            SLOT_SHIFT: begin
               valid <= shift_valid;
               rw    <= shift_rw;
               addr  <= shift_addr;
            end
            SLOT_LOAD: begin
               valid <= 1'b1;
               rw    <= load_rw;
               addr  <= load_addr;
            end
            default: begin
               valid <= valid;
               rw    <= rw;
               addr  <= addr;
            end
         endcase
      end
   end

endmodule

// File: rtl/ddr_cmd_queue.sv
// Collapsing command queue between the host command front end and the DDR5 scheduler.
// Slot 0 is the oldest entry. Occupied slots are always 0..count-1.
// When a command is popped, the entries above it shift down by one.
// Define CMDQ_READ_PRIO_EN to let the oldest read bypass older writes.
// That bypass is limited by a starvation counter that saturates at STARVE_MAX.
//
// Handshake: push = in_valid && in_ready, and pop = out_valid && out_ready.
// in_ready depends only on the registered count, never on out_ready.
module ddr_cmd_queue
   import cmdq_pkg::*;
#(
   parameter int DEPTH      = 8,
   parameter int ADDR_W     = 32,
   parameter int CNT_W      = $clog2(DEPTH + 1),
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic              in_rw,
   input  logic [ADDR_W-1:0] in_addr,
   output logic              in_ready,
   output logic              out_valid,
   output logic              out_rw,
   output logic [ADDR_W-1:0] out_addr,
   input  logic              out_ready,
   output logic [CNT_W-1:0]  count,
   output logic              rd_pending,
   output logic              wr_pending,
   output logic              cong
);

   localparam int SEL_W = $clog2(DEPTH);

   logic [DEPTH-1:0]  valid_q;
   logic [DEPTH-1:0]  rw_q;
   logic [ADDR_W-1:0] addr_q      [DEPTH];
   logic              shift_valid [DEPTH];
   logic              shift_rw    [DEPTH];
   logic [ADDR_W-1:0] shift_addr  [DEPTH];
   logic [1:0]        slot_mode   [DEPTH];
   logic [SEL_W-1:0]  sel_idx;
   logic [CNT_W-1:0]  sel_ext;
   logic [CNT_W-1:0]  last_idx;
   logic              push;
   logic              pop;

   assign in_ready  = (count != CNT_W'(DEPTH));
   assign out_valid = (count != '0);
   assign cong      = (count == CNT_W'(DEPTH));
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign last_idx  = count - CNT_W'(1);
   assign sel_ext   = CNT_W'(sel_idx);

   // With no queued command, sel_idx is 0, so out_* shows the slot 0 register.
   assign out_rw   = rw_q[sel_idx];
   assign out_addr = addr_q[sel_idx];

`ifdef CMDQ_READ_PRIO_EN
   localparam int SC_W = $clog2(STARVE_MAX + 1);

   logic [SC_W-1:0]  starve_cnt;
   logic             rd_found;
   logic [SEL_W-1:0] rd_idx;

   // Find the lowest-index valid read. Scanning downward leaves the lowest match last.
   always_comb begin
      rd_found = 1'b0;
      rd_idx   = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (valid_q[i] && (rw_q[i] == CMD_RD)) begin
            rd_found = 1'b1;
            rd_idx   = SEL_W'(i);
         end
      end
   end

   // Once the head write has been bypassed STARVE_MAX times, it is served next.
   assign sel_idx = (rd_found && (starve_cnt != SC_W'(STARVE_MAX))) ? rd_idx : '0;

   // Count the reads served ahead of a head write. Any pop of the head clears the count.
   always_ff @(posedge clk) begin
      if (rst) begin
         starve_cnt <= '0;
      end else if (pop) begin
         if (sel_idx == '0) begin
            starve_cnt <= '0;
         end else if (rw_q[0] == CMD_WR) begin
            starve_cnt <= starve_cnt + SC_W'(1);
         end
      end
   end
`else
   assign sel_idx = '0;

   logic unused_starve_max;
   assign unused_starve_max = (STARVE_MAX == 0);
`endif

   // Per-slot select. A pop collapses slots sel..count-2 and frees slot count-1.
   // A push fills the first slot left free after any collapse.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         slot_mode[i] = SLOT_HOLD;
         if (pop) begin
            if (CNT_W'(i) == last_idx) begin
               slot_mode[i] = push ? SLOT_LOAD : SLOT_SHIFT;
            end else if ((CNT_W'(i) >= sel_ext) && (CNT_W'(i) < last_idx)) begin
               slot_mode[i] = SLOT_SHIFT;
            end
         end else if (push && (CNT_W'(i) == count)) begin
            slot_mode[i] = SLOT_LOAD;
         end
      end
   end

   // Read/write pending flags over all valid slots.
   always_comb begin
      rd_pending = 1'b0;
      wr_pending = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         rd_pending = rd_pending | (valid_q[i] && (rw_q[i] == CMD_RD));
         wr_pending = wr_pending | (valid_q[i] && (rw_q[i] == CMD_WR));
      end
   end

   // Occupancy counter. A push and a pop in the same cycle leave it unchanged.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else begin
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Slot array. Each slot shifts in from the slot above it; the top slot shifts in an empty entry.
   for (genvar g = 0; g < DEPTH; g++) begin : g_slot
      if (g < DEPTH - 1) begin : g_src
         assign shift_valid[g] = valid_q[g+1];
         assign shift_rw[g]    = rw_q[g+1];
         assign shift_addr[g]  = addr_q[g+1];
      end else begin : g_top
         assign shift_valid[g] = 1'b0;
         assign shift_rw[g]    = 1'b0;
         assign shift_addr[g]  = '0;
      end

      cmdq_slot #(
         .ADDR_W (ADDR_W)
      ) u_slot (
         .clk         (clk),
         .rst         (rst),
         .mode        (slot_mode[g]),
         .load_rw     (in_rw),
         .load_addr   (in_addr),
         .shift_valid (shift_valid[g]),
         .shift_rw    (shift_rw[g]),
         .shift_addr  (shift_addr[g]),
         .valid       (valid_q[g]),
         .rw          (rw_q[g]),
         .addr        (addr_q[g])
      );
   end

endmodule

// File: tb/tb_ddr_cmd_queue.sv
// Self-checking bench for ddr_cmd_queue.
// The reference model is a queue of {rw, addr} entries. The served entry is removed from it,
// and new entries are appended. Read prioritisation is modelled when CMDQ_READ_PRIO_EN is defined.
module tb_ddr_cmd_queue;
   import cmdq_pkg::*;

   localparam int DEPTH      = 8;
   localparam int ADDR_W     = 32;
   localparam int CNT_W      = $clog2(DEPTH + 1);
   localparam int STARVE_MAX = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              in_valid = 1'b0;
   logic              in_rw = 1'b0;
   logic [ADDR_W-1:0] in_addr = '0;
   logic              in_ready;
   logic              out_valid;
   logic              out_rw;
   logic [ADDR_W-1:0] out_addr;
   logic              out_ready = 1'b0;
   logic [CNT_W-1:0]  count;
   logic              rd_pending;
   logic              wr_pending;
   logic              cong;

   // Reference model state: bit ADDR_W holds rw, and the low bits hold the address.
   logic [ADDR_W:0]   exp_q[$];
   logic [ADDR_W-1:0] pop_log[$];
   int                m_starve;
   int                n_checks;
   int                n_fail;

   ddr_cmd_queue #(
      .DEPTH      (DEPTH),
      .ADDR_W     (ADDR_W),
      .CNT_W      (CNT_W),
      .STARVE_MAX (STARVE_MAX)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_rw      (in_rw),
      .in_addr    (in_addr),
      .in_ready   (in_ready),
      .out_valid  (out_valid),
      .out_rw     (out_rw),
      .out_addr   (out_addr),
      .out_ready  (out_ready),
      .count      (count),
      .rd_pending (rd_pending),
      .wr_pending (wr_pending),
      .cong       (cong)
   );

   // Clock and watchdog.
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Index of the entry the queue should serve now.
   function automatic int model_sel();
`ifdef CMDQ_READ_PRIO_EN
      if (m_starve != STARVE_MAX) begin
         for (int j = 0; j < exp_q.size(); j++) begin
            if (exp_q[j][ADDR_W] == CMD_RD) return j;
         end
      end
`endif
      return 0;
   endfunction

   // One clock. Drive inputs, check outputs at the falling edge against the model, then advance the model.
   task automatic cycle(input logic v, input logic rw, input logic [ADDR_W-1:0] a, input logic ordy);
      int  m_cnt;
      int  m_sel;
      bit  m_rd;
      bit  m_wr;
      bit  m_push;
      bit  m_pop;
      in_valid  = v;
      in_rw     = rw;
      in_addr   = a;
      out_ready = ordy;
      @(negedge clk);
      m_cnt = exp_q.size();
      m_rd  = 1'b0;
      m_wr  = 1'b0;
      foreach (exp_q[j]) begin
         if (exp_q[j][ADDR_W] == CMD_WR) m_wr = 1'b1;
         else                            m_rd = 1'b1;
      end
      m_sel = model_sel();
      check("count", 64'(count), 64'(m_cnt));
      check("in_ready", 64'(in_ready), 64'(m_cnt != DEPTH));
      check("out_valid", 64'(out_valid), 64'(m_cnt != 0));
      check("cong", 64'(cong), 64'(m_cnt == DEPTH));
      check("rd_pending", 64'(rd_pending), 64'(m_rd));
      check("wr_pending", 64'(wr_pending), 64'(m_wr));
      if (m_cnt != 0) begin
         check("out_addr", 64'(out_addr), 64'(exp_q[m_sel][ADDR_W-1:0]));
         check("out_rw", 64'(out_rw), 64'(exp_q[m_sel][ADDR_W]));
      end
      m_push = v && (m_cnt != DEPTH);
      m_pop  = ordy && (m_cnt != 0);
      if (m_pop) begin
         pop_log.push_back(out_addr);
         if (m_sel == 0)                          m_starve = 0;
         else if (exp_q[0][ADDR_W] == CMD_WR)     m_starve++;
         exp_q.delete(m_sel);
      end
      if (m_push) exp_q.push_back({rw, a});
      @(posedge clk);
      #1;
   endtask

   // One-cycle synchronous reset. An optional in_valid models a reset that arrives mid-push.
   task automatic do_reset(input logic v);
      rst       = 1'b1;
      in_valid  = v;
      in_rw     = CMD_WR;
      in_addr   = $urandom;
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      rst      = 1'b0;
      in_valid = 1'b0;
      exp_q.delete();
      m_starve = 0;
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_count"}, 64'(count), 64'(0));
      check({tag, "_out_valid"}, 64'(out_valid), 64'(0));
      check({tag, "_in_ready"}, 64'(in_ready), 64'(1));
      check({tag, "_cong"}, 64'(cong), 64'(0));
      check({tag, "_rd_pending"}, 64'(rd_pending), 64'(0));
      check({tag, "_wr_pending"}, 64'(wr_pending), 64'(0));
   endtask

   initial begin
      logic [ADDR_W-1:0] exp_order[4];
      int                idx;
      n_checks = 0;
      n_fail   = 0;
      m_starve = 0;
      repeat (2) @(posedge clk);
      #1;
      do_reset(1'b0);
      check_idle("reset");

      // Fill to full with writes 0x10..0x17. A ninth push must be ignored.
      for (int i = 0; i < DEPTH; i++) cycle(1'b1, CMD_WR, ADDR_W'(32'h10 + i), 1'b0);
      cycle(1'b1, CMD_WR, ADDR_W'(32'h99), 1'b0);
      check("full_count", 64'(count), 64'(8));
      check("full_cong", 64'(cong), 64'(1));
      check("full_in_ready", 64'(in_ready), 64'(0));

      // Drain in FIFO order.
      pop_log.delete();
      for (int i = 0; i < DEPTH; i++) cycle(1'b0, CMD_RD, '0, 1'b1);
      check("drain_out_valid", 64'(out_valid), 64'(0));
      check("drain_count", 64'(count), 64'(0));
      check("drain_pops", 64'(pop_log.size()), 64'(8));
      for (int i = 0; i < DEPTH && i < pop_log.size(); i++)
         check("drain_order", 64'(pop_log[i]), 64'(32'h10 + i));

      // A push and a pop in the same cycle with three entries held.
      for (int i = 0; i < 3; i++) cycle(1'b1, CMD_WR, ADDR_W'(32'h20 + i), 1'b0);
      cycle(1'b1, CMD_WR, ADDR_W'(32'h40), 1'b1);
      check("pushpop_count", 64'(count), 64'(3));
      pop_log.delete();
      for (int i = 0; i < 3; i++) cycle(1'b0, CMD_RD, '0, 1'b1);
      check("pushpop_last", 64'(pop_log[2]), 64'(32'h40));

      // Mixed ordering test: queue [W1, W2, R3, R4].
      do_reset(1'b0);
      cycle(1'b1, CMD_WR, ADDR_W'(1), 1'b0);
      cycle(1'b1, CMD_WR, ADDR_W'(2), 1'b0);
      cycle(1'b1, CMD_RD, ADDR_W'(3), 1'b0);
      cycle(1'b1, CMD_RD, ADDR_W'(4), 1'b0);
      pop_log.delete();
      for (int i = 0; i < 4; i++) cycle(1'b0, CMD_RD, '0, 1'b1);
`ifdef CMDQ_READ_PRIO_EN
      exp_order = '{32'h3, 32'h4, 32'h1, 32'h2};
`else
      exp_order = '{32'h1, 32'h2, 32'h3, 32'h4};
`endif
      for (int i = 0; i < 4; i++) check("mixed_order", 64'(pop_log[i]), 64'(exp_order[i]));

`ifdef CMDQ_READ_PRIO_EN
      // Head write 0xA is bypassed by exactly STARVE_MAX reads, then served.
      do_reset(1'b0);
      cycle(1'b1, CMD_WR, ADDR_W'(32'hA), 1'b0);
      cycle(1'b1, CMD_RD, ADDR_W'(32'h100), 1'b0);
      pop_log.delete();
      for (int k = 0; k < 6; k++) cycle(1'b1, CMD_RD, ADDR_W'(32'h200 + k), 1'b1);
      idx = -1;
      foreach (pop_log[j]) if (pop_log[j] == ADDR_W'(32'hA) && idx < 0) idx = j;
      check("starve_bypass", 64'(idx), 64'(STARVE_MAX));
`endif

      // Mid-stream reset with a push in flight, then an immediate new push.
      do_reset(1'b0);
      for (int i = 0; i < 5; i++) cycle(1'b1, (i % 2 == 0) ? CMD_RD : CMD_WR, ADDR_W'(32'h30 + i), 1'b0);
      do_reset(1'b1);
      check_idle("midreset");
      cycle(1'b1, CMD_RD, ADDR_W'(32'h55), 1'b0);
      check("post_reset_count", 64'(count), 64'(1));
      check("post_reset_addr", 64'(out_addr), 64'(32'h55));

      // Randomised traffic against the model.
      for (int n = 0; n < 2000; n++) begin
         if ($urandom_range(0, 199) == 0) do_reset($urandom_range(0, 1) == 1);
         else cycle($urandom_range(0, 99) < 60, $urandom_range(0, 1) == 1,
                    ADDR_W'($urandom), $urandom_range(0, 99) < 50);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
